data_ram_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the 256-byte data RAM. The CPU load/store unit (port 0) and the debug/program-loader port (port 1) share the single RAM interface. The arbiter grants one access at a time, checks alignment, and normalises the byte/half/word size code. It drives the RAM's `we`/`re`/`flag`/`a`/`wd` pins and returns read data and completion per port.

---
 rtl/data_ram_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single data-RAM command port between the CPU load/store unit
//   (port 0) and the debug/program-loader port (port 1). One access is granted
//   at a time. The arbiter checks alignment, normalises the size code and
//   sequences the RAM strobes. It returns per-port completion, error and read data.
//
// Ports
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   reqN/weN/flagN/addrN/wdataN: request and its fields, held until ackN
//   ackN, errN                 : one-cycle completion pulse, misalignment flag
//   rdataN                     : last load result of port N (sign-extended by RAM)
//   ram_we/ram_re              : RAM write/read strobes (high only in ACCESS)
//   ram_flag/ram_a/ram_wd      : RAM command fields, held outside ACCESS
//   ram_rd                     : RAM combinational read data
module data_ram_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [1:0]        flag0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [31:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [1:0]        flag1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [31:0]       rdata1,
  output logic              ram_we,
  output logic              ram_re,
  output logic [1:0]        ram_flag,
  output logic [ADDR_W-1:0] ram_a,
  output logic [31:0]       ram_wd,
  input  logic [31:0]       ram_rd
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              last_grant_q, last_grant_d;
  logic              sel_q,        sel_d;
  logic              ack0_q,       ack0_d;
  logic              ack1_q,       ack1_d;
  logic              err0_q,       err0_d;
  logic              err1_q,       err1_d;
  logic [DATA_W-1:0] rdata0_q,     rdata0_d;
  logic [DATA_W-1:0] rdata1_q,     rdata1_d;
  logic              ram_we_q,     ram_we_d;
  logic              ram_re_q,     ram_re_d;
  logic [FLAG_W-1:0] ram_flag_q,   ram_flag_d;
  logic [ADDR_W-1:0] ram_a_q,      ram_a_d;
  logic [DATA_W-1:0] ram_wd_q,     ram_wd_d;

  // Winner selection and the selected request's fields
  logic              any_req_c;
  logic              win_c;
  logic              win_we_c;
  logic [FLAG_W-1:0] win_flag_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;
  logic              mis_c;
  logic [FLAG_W-1:0] norm_flag_c;

  // Request mux: arbitration, alignment check and size normalisation
  always_comb begin : req_mux
    any_req_c = req0 | req1;
    win_c     = 1'b0;
    if (req0 && req1) begin
      // Round-robin hands the tie to the port not granted last
      win_c = (FIXED_PRIO != 32'd0) ? 1'b0 : ~last_grant_q;
    end else begin
      win_c = req1;
    end

    win_we_c    = win_c ? we1    : we0;
    win_flag_c  = win_c ? flag1  : flag0;
    win_addr_c  = win_c ? addr1  : addr0;
    win_wdata_c = win_c ? wdata1 : wdata0;

    // Natural alignment keeps half/word accesses from wrapping the RAM top
    mis_c = 1'b0;
    if (win_flag_c[1]) begin
      mis_c = (win_addr_c[1:0] != 2'b00);
    end else if (win_flag_c[0]) begin
      mis_c = win_addr_c[0];
    end

    norm_flag_c = win_flag_c[1] ? 2'b11 : win_flag_c;
  end

  // State register and all datapath/output flops
  always_ff @(posedge clk) begin : regs
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_flag_q   <= '0;
      ram_a_q      <= '0;
      ram_wd_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      ram_flag_q   <= ram_flag_d;
      ram_a_q      <= ram_a_d;
      ram_wd_q     <= ram_wd_d;
    end
  end

  // Next-state logic
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          state_d = mis_c ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered so each value is
  // computed one cycle ahead of the state in which it must appear
  always_comb begin : outputs
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    ram_flag_d   = ram_flag_q;
    ram_a_d      = ram_a_q;
    ram_wd_d     = ram_wd_q;

    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          last_grant_d = win_c;
          sel_d        = win_c;
          if (mis_c) begin
            // Misaligned: respond next cycle, RAM pins untouched
            if (win_c) begin
              ack1_d = 1'b1;
              err1_d = 1'b1;
            end else begin
              ack0_d = 1'b1;
              err0_d = 1'b1;
            end
          end else begin
            ram_a_d    = win_addr_c;
            ram_wd_d   = win_wdata_c;
            ram_flag_d = norm_flag_c;
            ram_we_d   = win_we_c;
            ram_re_d   = ~win_we_c;
          end
        end
      end
      S_ACCESS: begin
        // Load data is captured at the edge that ends ACCESS
        if (ram_re_q) begin
          if (sel_q) begin
            rdata1_d = ram_rd;
          end else begin
            rdata0_d = ram_rd;
          end
        end
        if (sel_q) begin
          ack1_d = 1'b1;
        end else begin
          ack0_d = 1'b1;
        end
      end
      S_RESP: begin
      end
      default: begin
      end
    endcase
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ram_we   = ram_we_q;
  assign ram_re   = ram_re_q;
  assign ram_flag = ram_flag_q;
  assign ram_a    = ram_a_q;
  assign ram_wd   = ram_wd_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter: RAM model, scoreboard per port, reference
// memory image, directed scenarios followed by randomized traffic.
module tb_data_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [1:0]  flag0, flag1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        ram_we, ram_re;
  logic [1:0]  ram_flag;
  logic [7:0]  ram_a;
  logic [31:0] ram_wd, ram_rd;

  // Second instance with fixed priority
  logic        f_req0, f_req1;
  logic        f_ack0, f_err0, f_ack1, f_err1;
  logic [31:0] f_rdata0, f_rdata1;
  logic        f_ram_we, f_ram_re;
  logic [1:0]  f_ram_flag;
  logic [7:0]  f_ram_a;
  logic [31:0] f_ram_wd;
  logic [31:0] f_ram_rd;

  data_ram_arbiter #(.FIXED_PRIO(0), .ADDR_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .flag0(flag0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .flag1(flag1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_re(ram_re), .ram_flag(ram_flag), .ram_a(ram_a),
    .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  data_ram_arbiter #(.FIXED_PRIO(1), .ADDR_W(8)) u_fix (
    .clk(clk), .reset(reset),
    .req0(f_req0), .we0(1'b0), .flag0(2'b00), .addr0(8'h00), .wdata0(32'h0),
    .ack0(f_ack0), .err0(f_err0), .rdata0(f_rdata0),
    .req1(f_req1), .we1(1'b0), .flag1(2'b00), .addr1(8'h01), .wdata1(32'h0),
    .ack1(f_ack1), .err1(f_err1), .rdata1(f_rdata1),
    .ram_we(f_ram_we), .ram_re(f_ram_re), .ram_flag(f_ram_flag), .ram_a(f_ram_a),
    .ram_wd(f_ram_wd), .ram_rd(f_ram_rd)
  );

  assign f_ram_rd = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model (byte array, sign-extending reads) ----------
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);

  always @(posedge clk) begin
    if (!reset && ram_we) begin
      mem[ram_a] <= ram_wd[7:0];
      if (ram_flag != 2'b00) mem[8'(ram_a + 8'd1)] <= ram_wd[15:8];
      if (ram_flag[1]) begin
        mem[8'(ram_a + 8'd2)] <= ram_wd[23:16];
        mem[8'(ram_a + 8'd3)] <= ram_wd[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[ram_a];
    b1 = mem[8'(ram_a + 8'd1)];
    b2 = mem[8'(ram_a + 8'd2)];
    b3 = mem[8'(ram_a + 8'd3)];
    case (ram_flag)
      2'b00:   ram_rd = {{24{b0[7]}}, b0};
      2'b01:   ram_rd = {{16{b1[7]}}, b1, b0};
      default: ram_rd = {b3, b2, b1, b0};
    endcase
  end

  // ---------------- reference model and scoreboard ------------------------
  int          ref_mem [256];
  logic [31:0] rd_hold [2];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  int          ack_port_log [$];
  int          ack_cyc_log [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          we_cnt = 0, re_cnt = 0, exp_we_cnt = 0, exp_re_cnt = 0;
  logic [1:0]  last_we_flag = 2'b00;
  int          f_cnt0 = 0, f_cnt1 = 0;

  initial for (int i = 0; i < 256; i++) ref_mem[i] = i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int size_of(input logic [1:0] fl);
    return (fl == 2'b00) ? 1 : (fl == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] fl);
    longint v;
    int     n;
    n = size_of(fl);
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[(int'(a) + i) % 256]);
    if (n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // Issue one access on port p, wait for its ack; lat = cycles from request to ack
  task automatic do_access(input int p, input logic we, input logic [1:0] fl,
                           input logic [7:0] a, input logic [31:0] wd, output int lat);
    logic mis;
    int   n;
    n   = size_of(fl);
    mis = (int'(a) % n) != 0;
    if (!mis) begin
      if (we) begin
        exp_we_cnt++;
        for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 256] = int'(wd[8*i +: 8]);
      end else begin
        exp_re_cnt++;
        rd_hold[p] = ref_load(a, fl);
      end
    end
    if (p == 0) exp_q0.push_back({mis, rd_hold[0]});
    else        exp_q1.push_back({mis, rd_hold[1]});
    if (p == 0) begin req0 = 1'b1; we0 = we; flag0 = fl; addr0 = a; wdata0 = wd; end
    else        begin req1 = 1'b1; we1 = we; flag1 = fl; addr1 = a; wdata1 = wd; end
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: port %0d got no ack within 40 cycles, required an ack", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  // Monitor: pops expected responses whenever the DUT acks
  always @(negedge clk) begin
    logic [32:0] e;
    chk("dual_ack", 32'(ack0 & ack1), 32'h0);
    if (ack0) begin
      ack_port_log.push_back(0);
      ack_cyc_log.push_back(cyc);
      if (exp_q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ack0_unexpected: got ack0=1, required no ack");
      end else begin
        e = exp_q0.pop_front();
        chk("err0", 32'(err0), 32'(e[32]));
        chk("rdata0", rdata0, e[31:0]);
      end
    end else begin
      chk("err0_idle", 32'(err0), 32'h0);
    end
    if (ack1) begin
      ack_port_log.push_back(1);
      ack_cyc_log.push_back(cyc);
      if (exp_q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ack1_unexpected: got ack1=1, required no ack");
      end else begin
        e = exp_q1.pop_front();
        chk("err1", 32'(err1), 32'(e[32]));
        chk("rdata1", rdata1, e[31:0]);
      end
    end else begin
      chk("err1_idle", 32'(err1), 32'h0);
    end
    if (ram_we) begin
      we_cnt++;
      last_we_flag = ram_flag;
    end
    if (ram_re) re_cnt++;
    if (ram_we || ram_re) begin
      chk("strobe_excl", 32'(ram_we & ram_re), 32'h0);
      chk("flag_norm", 32'(ram_flag == 2'b10), 32'h0);
    end
    if (f_ack0) f_cnt0++;
    if (f_ack1) f_cnt1++;
  end

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rd_hold[0] = 32'h0;
    rd_hold[1] = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ---------------------------------------------
  initial begin
    int lat, w0, r0;
    reset = 1'b1;
    req0 = 0; we0 = 0; flag0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; flag1 = 0; addr1 = 0; wdata1 = 0;
    f_req0 = 0; f_req1 = 0;
    pulse_reset();

    // Reset values
    @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'h0);
    chk("rst_ack1", 32'(ack1), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_re", 32'(ram_re), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_ram_a", 32'(ram_a), 32'h0);
    chk("rst_ram_wd", ram_wd, 32'h0);
    chk("rst_ram_flag", 32'(ram_flag), 32'h0);
    @(posedge clk); #1;

    // Word load @0x00 on port 0
    do_access(0, 1'b0, 2'b10, 8'h00, 32'h0, lat);
    chk("lat_word_load", 32'(lat), 32'd2);
    chk("word_load_val", rdata0, 32'h03020100);

    // Byte store 0x80 @0x11 on port 1, then signed byte load
    w0 = we_cnt;
    do_access(1, 1'b1, 2'b00, 8'h11, 32'h0000_0080, lat);
    chk("byte_store_we_pulses", 32'(we_cnt - w0), 32'd1);
    chk("byte_store_flag", 32'(last_we_flag), 32'h0);
    do_access(1, 1'b0, 2'b00, 8'h11, 32'h0, lat);
    chk("byte_load_sext", rdata1, 32'hFFFF_FF80);

    // Misaligned half load and word store
    w0 = we_cnt;
    r0 = re_cnt;
    do_access(0, 1'b0, 2'b01, 8'h05, 32'h0, lat);
    chk("lat_mis_half", 32'(lat), 32'd1);
    chk("mis_rdata0_kept", rdata0, 32'h03020100);
    do_access(1, 1'b1, 2'b10, 8'h06, 32'hAAAA_AAAA, lat);
    chk("lat_mis_word", 32'(lat), 32'd1);
    chk("mis_no_we", 32'(we_cnt - w0), 32'd0);
    chk("mis_no_re", 32'(re_cnt - r0), 32'd0);
    do_access(1, 1'b0, 2'b10, 8'h04, 32'h0, lat);
    chk("mis_ram_unchanged", rdata1, 32'h0706_0504);

    // Top-of-RAM word load is aligned
    do_access(1, 1'b0, 2'b11, 8'hFC, 32'h0, lat);
    chk("top_word_load", rdata1, 32'hFFFE_FDFC);

    // Flag 10 is normalised to 11
    do_access(0, 1'b1, 2'b10, 8'h20, 32'hDEAD_BEEF, lat);
    chk("flag10_norm", 32'(last_we_flag), 32'h3);
    do_access(0, 1'b0, 2'b10, 8'h20, 32'h0, lat);
    chk("flag10_readback", rdata0, 32'hDEAD_BEEF);

    // Round-robin with both ports requesting continuously
    pulse_reset();
    ack_port_log.delete();
    ack_cyc_log.delete();
    fork
      begin
        int l;
        do_access(0, 1'b0, 2'b10, 8'h30, 32'h0, l);
        do_access(0, 1'b0, 2'b10, 8'h34, 32'h0, l);
      end
      begin
        int l;
        do_access(1, 1'b0, 2'b10, 8'h90, 32'h0, l);
        do_access(1, 1'b0, 2'b10, 8'h94, 32'h0, l);
      end
    join
    chk("rr_ack_count", 32'(ack_port_log.size()), 32'd4);
    if (ack_port_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr_order_%0d", i), 32'(ack_port_log[i]), 32'(i % 2));
        if (i > 0) chk($sformatf("rr_spacing_%0d", i), 32'(ack_cyc_log[i] - ack_cyc_log[i-1]), 32'd3);
      end
    end

    // Fixed priority: port 0 starves port 1 while held
    f_cnt0 = 0;
    f_cnt1 = 0;
    f_req0 = 1'b1;
    f_req1 = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("fix_starve_p1", 32'(f_cnt1), 32'd0);
    chk("fix_p0_served", 32'(f_cnt0 >= 4), 32'd1);
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (f_ack0) seen = 1;
      end
      chk("fix_p0_ack_seen", 32'(seen), 32'd1);
    end
    @(posedge clk); #1;
    f_req0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("fix_p1_after_release", 32'(f_cnt1 >= 1), 32'd1);
    f_req1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset asserted during the ACCESS cycle of a port 0 store
    req0 = 1'b1; we0 = 1'b1; flag0 = 2'b10; addr0 = 8'h40; wdata0 = 32'h1122_3344;
    exp_we_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("rst_access_we_seen", 32'(ram_we), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_hold[0] = 32'h0;
    rd_hold[1] = 32'h0;
    @(negedge clk);
    chk("rst_access_no_ack0", 32'(ack0), 32'h0);
    chk("rst_access_we_low", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    do_access(0, 1'b0, 2'b10, 8'h40, 32'h0, lat);
    chk("rst_access_next_lat", 32'(lat), 32'd2);
    chk("rst_access_store_lost", rdata0, 32'h4342_4140);

    // Randomized traffic, each port in its own half of the RAM
    fork
      begin
        int l;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_access(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 127)), $urandom, l);
        end
      end
      begin
        int l;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_access(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(128, 255)), $urandom, l);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("total_we_pulses", 32'(we_cnt), 32'(exp_we_cnt));
    chk("total_re_pulses", 32'(re_cnt), 32'(exp_re_cnt));
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
